load_store_unit: RTL and testbench

Initiator side of the 256-byte big-endian data memory port. Accepts one load or store request at a time from the pipeline's MEM stage and sequences it onto the memory as byte-sized accesses (Size=00), most-significant byte first. Loads are assembled into a 32-bit result, zero- or sign-extended, and returned with a one-cycle response pulse. Out-of-range and illegal-size requests are rejected without touching memory.

---
 rtl/load_store_unit_pkg.sv | 17 +
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - size and state encodings shared by the LSU, data memory and decode
package load_store_unit_pkg;

   localparam int MEM_BYTES_DEFAULT = 256;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial, MSB-first initiator for the big-endian data memory port
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_DI,
   input  logic [31:0] mem_DO,
   output logic [1:0]  mem_Size,
   output logic        mem_RW,
   output logic        mem_E
);

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [2:0] n,
                                               input logic sgn);
      case (n)
         3'd1:    extend_load = {{24{sgn & v[7]}}, v[7:0]};
         3'd2:    extend_load = {{16{sgn & v[15]}}, v[15:0]};
         default: extend_load = v;
      endcase
   endfunction

   lsu_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  nbytes_q, nbytes_d;
   logic        rw_q, rw_d;
   logic        sgn_q, sgn_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] acc_q, acc_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [31:0] mem_A_q, mem_A_d;
   logic [31:0] mem_DI_q, mem_DI_d;
   logic        mem_RW_q, mem_RW_d;
   logic        mem_E_q, mem_E_d;

   logic [2:0]  req_n;
   logic [32:0] req_last;
   logic        req_err;
   logic [31:0] req_aligned;
   logic [31:0] acc_shift;
   logic        last_byte;
   logic        unused_mem_do;

   // Last byte address in 33 bits so a request wrapping past 2^32 is caught as out of range.
   assign req_n     = size_bytes(req_size);
   assign req_last  = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;
   assign req_err   = (req_size == SZ_ILL) || (req_last > 33'(MEM_BYTES - 1));
   assign acc_shift = {acc_q[23:0], mem_DO[7:0]};
   assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
   assign unused_mem_do = ^mem_DO[31:8];

   // Store data is left-justified once at accept so each byte is simply the top byte of a shifter.
   always_comb begin
      req_aligned = req_wdata;
      case (req_size)
         SZ_BYTE: req_aligned = {req_wdata[7:0], 24'h0};
         SZ_HALF: req_aligned = {req_wdata[15:0], 16'h0};
         default: req_aligned = req_wdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      rw_d        = rw_q;
      sgn_d       = sgn_q;
      sdata_d     = sdata_q;
      acc_d       = acc_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      mem_A_d     = '0;
      mem_DI_d    = '0;
      mem_RW_d    = 1'b0;
      mem_E_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               rw_d        = req_rw;
               sgn_d       = req_signed;
               nbytes_d    = req_n;
               cnt_d       = '0;
               acc_d       = '0;
               if (req_err) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d  = ST_XFER;
                  mem_A_d  = req_addr;
                  mem_RW_d = req_rw;
                  mem_E_d  = req_rw;
                  mem_DI_d = req_rw ? {24'h0, req_aligned[31:24]} : '0;
                  sdata_d  = {req_aligned[23:0], 8'h0};
               end
            end
         end
         ST_XFER: begin
            acc_d = acc_shift;
            if (last_byte) begin
               // The final byte is folded in straight from mem_DO so the result is ready in RESP.
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rw_q ? '0 : extend_load(acc_shift, nbytes_q, sgn_q);
            end else begin
               cnt_d    = cnt_q + 2'd1;
               mem_A_d  = mem_A_q + 32'd1;
               mem_RW_d = rw_q;
               mem_E_d  = rw_q;
               mem_DI_d = rw_q ? {24'h0, sdata_q[31:24]} : '0;
               sdata_d  = {sdata_q[23:0], 8'h0};
            end
         end
         ST_RESP: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         nbytes_q    <= '0;
         rw_q        <= 1'b0;
         sgn_q       <= 1'b0;
         sdata_q     <= '0;
         acc_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_A_q     <= '0;
         mem_DI_q    <= '0;
         mem_RW_q    <= 1'b0;
         mem_E_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         rw_q        <= rw_d;
         sgn_q       <= sgn_d;
         sdata_q     <= sdata_d;
         acc_q       <= acc_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_A_q     <= mem_A_d;
         mem_DI_q    <= mem_DI_d;
         mem_RW_q    <= mem_RW_d;
         mem_E_q     <= mem_E_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_A     = mem_A_q;
   assign mem_DI    = mem_DI_q;
   assign mem_Size  = SZ_BYTE;
   assign mem_RW    = mem_RW_q;
   assign mem_E     = mem_E_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte memory model
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rw = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_DI;
   logic [31:0] mem_DO;
   logic [1:0]  mem_Size;
   logic        mem_RW;
   logic        mem_E;

   logic [7:0]  mem [0:255];
   logic        tb_clr = 1'b0;
   logic        tb_we = 1'b0;
   logic [7:0]  tb_waddr = '0;
   logic [7:0]  tb_wdata = '0;

   int          total = 0;
   int          bad = 0;
   logic [32:0] sb_q[$];
   logic [31:0] a_log[$];
   logic [7:0]  d_log[$];
   logic        e_log[$];
   int          obs_lat;
   int          obs_we;
   logic        obs_rdy;
   logic [31:0] obs_rd;
   logic        obs_err;

   load_store_unit #(.MEM_BYTES(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_A(mem_A), .mem_DI(mem_DI), .mem_DO(mem_DO), .mem_Size(mem_Size),
      .mem_RW(mem_RW), .mem_E(mem_E)
   );

   always #5 clk = ~clk;

   assign mem_DO = {24'h0, mem[mem_A[7:0]]};

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h55;
      end else if (mem_E) begin
         mem[mem_A[7:0]] <= mem_DI[7:0];
      end else if (tb_we) begin
         mem[tb_waddr] <= tb_wdata;
      end
   end

   function automatic logic [32:0] ref_result(input logic rw, input logic [1:0] sz,
                                              input logic sgn, input logic [31:0] addr);
      int n;
      logic [63:0] last;
      logic [31:0] v;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
      last = {32'd0, addr} + 64'(n) - 64'd1;
      if (sz == 2'b11 || last > 64'd255) return {1'b1, 32'd0};
      if (rw) return 33'd0;
      v = '0;
      for (int k = 0; k < n; k++) v = {v[23:0], mem[addr[7:0] + 8'(k)]};
      if (n == 1 && sgn && v[7])  v[31:8]  = 24'hFFFFFF;
      if (n == 2 && sgn && v[15]) v[31:16] = 16'hFFFF;
      return {1'b0, v};
   endfunction

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic send(input logic rw, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
      int guard;
      @(negedge clk);
      req_rw = rw; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      sb_q.push_back(ref_result(rw, sz, sgn, addr));
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
      req_rw = 1'($urandom); req_signed = 1'($urandom);
   endtask

   task automatic observe();
      a_log.delete(); d_log.delete(); e_log.delete();
      obs_lat = 0; obs_we = 0; obs_rdy = 1'b0; obs_rd = '0; obs_err = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         a_log.push_back(mem_A); d_log.push_back(mem_DI[7:0]); e_log.push_back(mem_E);
         if (mem_E) obs_we++;
         if (req_ready) obs_rdy = 1'b1;
         if (rsp_valid) begin
            obs_lat = c; obs_rd = rsp_rdata; obs_err = rsp_err;
            break;
         end
      end
   endtask

   task automatic run(input logic rw, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd);
      send(rw, sz, sgn, addr, wd);
      observe();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tb_clr = 1'b1;
      @(negedge clk);
      tb_clr = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin bad++; $display("FAIL reset_rsp got=%b/%b/%h want=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
      total++; if ({mem_A, mem_DI, mem_Size, mem_RW, mem_E} !== 68'd0) begin bad++; $display("FAIL reset_mem got A=%h DI=%h Sz=%b RW=%b E=%b want all 0", mem_A, mem_DI, mem_Size, mem_RW, mem_E); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_load();
      logic [32:0] exp;
      poke(0, 8'h11); poke(1, 8'h22); poke(2, 8'h33); poke(3, 8'h84);
      run(1'b0, SZ_WORD, 1'b1, 32'd0, 32'h0);
      exp = sb_q.pop_front();
      total++; if ({obs_err, obs_rd} !== exp) begin bad++; $display("FAIL word_load_sb got=%b/%h want=%b/%h", obs_err, obs_rd, exp[32], exp[31:0]); end
      total++; if (obs_rd !== 32'h11223384) begin bad++; $display("FAIL word_load_val got=%h want=11223384", obs_rd); end
      total++; if (obs_lat !== 5) begin bad++; $display("FAIL word_load_lat got=%0d want=5", obs_lat); end
      total++; if (a_log.size() < 4 || {a_log[0][7:0], a_log[1][7:0], a_log[2][7:0], a_log[3][7:0]} !== 32'h00010203)
         begin bad++; $display("FAIL word_load_addrs got %0d entries want 0,1,2,3", a_log.size()); end
      total++; if (obs_we !== 0 || obs_rdy !== 1'b0) begin bad++; $display("FAIL word_load_ctrl got we=%0d rdy=%b want 0/0", obs_we, obs_rdy); end
   endtask

   task automatic test_narrow_loads();
      logic [32:0] exp;
      logic [31:0] want [4] = '{32'hFFFF84AA, 32'h000084AA, 32'h0000007F, 32'hFFFFFF84};
      logic [1:0]  szs  [4] = '{SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE};
      logic        sgns [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] adrs [4] = '{32'd2, 32'd2, 32'd5, 32'd3};
      poke(2, 8'h84); poke(3, 8'hAA); poke(5, 8'h7F);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) poke(3, 8'h84);
         run(1'b0, szs[i], sgns[i], adrs[i], 32'h0);
         exp = sb_q.pop_front();
         total++; if ({obs_err, obs_rd} !== exp || obs_rd !== want[i])
            begin bad++; $display("FAIL narrow_load_%0d got=%b/%h want=0/%h model=%h", i, obs_err, obs_rd, want[i], exp[31:0]); end
         total++; if (obs_lat !== ((szs[i] == SZ_HALF) ? 3 : 2))
            begin bad++; $display("FAIL narrow_load_lat_%0d got=%0d want=%0d", i, obs_lat, (szs[i] == SZ_HALF) ? 3 : 2); end
      end
   endtask

   task automatic test_store();
      logic [32:0] exp;
      logic [7:0]  want_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      int          seen;
      run(1'b1, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF);
      exp = sb_q.pop_front();
      total++; if ({obs_err, obs_rd} !== exp || obs_lat !== 5) begin bad++; $display("FAIL store_rsp got=%b/%h lat=%0d want=0/0 lat=5", obs_err, obs_rd, obs_lat); end
      total++; if (obs_we !== 4) begin bad++; $display("FAIL store_we_cycles got=%0d want=4", obs_we); end
      seen = 0;
      for (int k = 0; k < e_log.size(); k++) begin
         if (e_log[k] && seen < 4) begin
            total++; if (d_log[k] !== want_b[seen] || a_log[k] !== 32'd8 + 32'(seen) || mem_RW === 1'bx)
               begin bad++; $display("FAIL store_byte_%0d got A=%0d DI=%h want A=%0d DI=%h", seen, a_log[k], d_log[k], 8 + seen, want_b[seen]); end
            seen++;
         end
      end
      run(1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
      exp = sb_q.pop_front();
      total++; if (obs_rd !== 32'hDEADBEEF || {obs_err, obs_rd} !== exp) begin bad++; $display("FAIL store_readback got=%h want=deadbeef", obs_rd); end
      run(1'b1, SZ_HALF, 1'b0, 32'd20, 32'h1234CAFE);
      void'(sb_q.pop_front());
      total++; if ({mem[20], mem[21], mem[22]} !== 24'hCAFE55 || obs_we !== 2)
         begin bad++; $display("FAIL half_store got=%h%h%h we=%0d want=cafe55 we=2", mem[20], mem[21], mem[22], obs_we); end
   endtask

   task automatic test_errors();
      logic [32:0] exp;
      logic [1:0]  szs  [5] = '{SZ_WORD, SZ_ILL, SZ_HALF, SZ_BYTE, SZ_WORD};
      logic        rws  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] adrs [5] = '{32'd253, 32'd0, 32'hFFFFFFFF, 32'd255, 32'd252};
      logic        errs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int          lats [5] = '{1, 1, 1, 2, 5};
      for (int i = 0; i < 5; i++) begin
         run(rws[i], szs[i], 1'b1, adrs[i], 32'hFFFFFFFF);
         exp = sb_q.pop_front();
         total++; if (obs_err !== errs[i] || {obs_err, obs_rd} !== exp)
            begin bad++; $display("FAIL err_case_%0d got=%b/%h want=%b/%h", i, obs_err, obs_rd, errs[i], exp[31:0]); end
         total++; if (obs_lat !== lats[i] || obs_we !== 0)
            begin bad++; $display("FAIL err_timing_%0d got lat=%0d we=%0d want lat=%0d we=0", i, obs_lat, obs_we, lats[i]); end
      end
      total++; if (mem[0] !== 8'h11) begin bad++; $display("FAIL err_mem_untouched got=%h want=11", mem[0]); end
   endtask

   task automatic test_back_to_back();
      logic [32:0] exp;
      int          rsp_cyc[$];
      logic        rdy_early;
      int          c0, c1;
      @(negedge clk);
      req_rw = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'd0; req_valid = 1'b1;
      sb_q.push_back(ref_result(1'b0, SZ_WORD, 1'b0, 32'd0));
      @(posedge clk);
      #1;
      req_size = SZ_BYTE; req_signed = 1'b1; req_addr = 32'd3;
      sb_q.push_back(ref_result(1'b0, SZ_BYTE, 1'b1, 32'd3));
      rdy_early = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c <= 5 && req_ready) rdy_early = 1'b1;
         if (c == 7) req_valid = 1'b0;
         if (rsp_valid) begin
            rsp_cyc.push_back(c);
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL b2b_extra_rsp got=%h at cycle %0d want none", rsp_rdata, c);
            end else begin
               exp = sb_q.pop_front();
               if ({rsp_err, rsp_rdata} !== exp) begin bad++; $display("FAIL b2b_data got=%b/%h want=%b/%h", rsp_err, rsp_rdata, exp[32], exp[31:0]); end
            end
         end
      end
      total++; if (rdy_early !== 1'b0) begin bad++; $display("FAIL b2b_ready got=1 during first request want=0"); end
      c0 = (rsp_cyc.size() > 0) ? rsp_cyc[0] : -1;
      c1 = (rsp_cyc.size() > 1) ? rsp_cyc[1] : -1;
      total++; if (rsp_cyc.size() !== 2 || c0 !== 5 || c1 !== 8)
         begin bad++; $display("FAIL b2b_timing got n=%0d c0=%0d c1=%0d want n=2 c0=5 c1=8", rsp_cyc.size(), c0, c1); end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_store();
      logic [32:0] exp;
      int          rsp_seen;
      send(1'b1, SZ_WORD, 1'b0, 32'd40, 32'hA1B2C3D4);
      void'(sb_q.pop_back());
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      total++; if (mem_E !== 1'b1 || mem_A !== 32'd42) begin bad++; $display("FAIL mid_store_pre got E=%b A=%0d want E=1 A=42", mem_E, mem_A); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (mem_E !== 1'b0) begin bad++; $display("FAIL mid_store_async_drop got E=%b want=0", mem_E); end
      rsp_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp_valid) rsp_seen++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp_valid) rsp_seen++;
      end
      total++; if (rsp_seen !== 0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_store_rsp got rsp=%0d rdy=%b want 0/1", rsp_seen, req_ready); end
      total++; if ({mem[40], mem[41], mem[42], mem[43]} !== 32'hA1B25555)
         begin bad++; $display("FAIL mid_store_partial got=%h%h%h%h want=a1b25555", mem[40], mem[41], mem[42], mem[43]); end
      run(1'b0, SZ_WORD, 1'b0, 32'd40, 32'h0);
      exp = sb_q.pop_front();
      total++; if (obs_rd !== 32'hA1B25555 || {obs_err, obs_rd} !== exp || obs_lat !== 5)
         begin bad++; $display("FAIL mid_store_readback got=%h lat=%0d want=a1b25555 lat=5", obs_rd, obs_lat); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_load();
      test_narrow_loads();
      test_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
